// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the RV32 load/store
// port. It accepts one request at a time over valid/ready, waits
// WAIT_CYCLES extra cycles, then commits a little-endian byte, half or word
// access. It returns the result on a valid/ready response channel.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  // Storage has no reset: contents survive rst and are undefined until written.
  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] word_idx_s;
  logic [31:0]   rd_word_s;
  logic          legal_f3_s;
  logic          misaligned_s;
  logic          out_of_range_s;
  logic          err_s;
  logic          commit_s;
  logic [7:0]    lane_byte_s;
  logic [15:0]   lane_half_s;
  logic [31:0]   load_val_s;
  logic [3:0]    be_s;
  logic [31:0]   st_data_s;

  assign word_idx_s = addr_q[AW+1:2];
  assign rd_word_s  = mem[word_idx_s];
  assign commit_s   = (state_q == ST_WAIT) && (cnt_q == 4'd0);

  // Classify the latched request: funct3 legality, alignment and range.
  always_comb begin
    legal_f3_s   = 1'b0;
    misaligned_s = 1'b0;
    if (write_q) begin
      legal_f3_s = (funct3_q == 3'b000) || (funct3_q == 3'b001) ||
                   (funct3_q == 3'b010);
    end else begin
      legal_f3_s = (funct3_q == 3'b000) || (funct3_q == 3'b001) ||
                   (funct3_q == 3'b010) || (funct3_q == 3'b100) ||
                   (funct3_q == 3'b101);
    end
    case (funct3_q[1:0])
      2'b01:   misaligned_s = addr_q[0];
      2'b10:   misaligned_s = (addr_q[1:0] != 2'b00);
      default: misaligned_s = 1'b0;
    endcase
    out_of_range_s = ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
    err_s = !legal_f3_s || misaligned_s || out_of_range_s;
  end

  // Extract the addressed lane from the stored word and extend it.
  always_comb begin
    case (addr_q[1:0])
      2'b00:   lane_byte_s = rd_word_s[7:0];
      2'b01:   lane_byte_s = rd_word_s[15:8];
      2'b10:   lane_byte_s = rd_word_s[23:16];
      2'b11:   lane_byte_s = rd_word_s[31:24];
      default: lane_byte_s = 8'h00;
    endcase
    if (addr_q[1]) begin
      lane_half_s = rd_word_s[31:16];
    end else begin
      lane_half_s = rd_word_s[15:0];
    end
    case (funct3_q)
      3'b000:  load_val_s = {{24{lane_byte_s[7]}}, lane_byte_s};
      3'b001:  load_val_s = {{16{lane_half_s[15]}}, lane_half_s};
      3'b010:  load_val_s = rd_word_s;
      3'b100:  load_val_s = {24'h000000, lane_byte_s};
      3'b101:  load_val_s = {16'h0000, lane_half_s};
      default: load_val_s = 32'h0000_0000;
    endcase
  end

  // Build byte enables and lane-replicated store data.
  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        be_s      = 4'b0001 << addr_q[1:0];
        st_data_s = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_s      = addr_q[1] ? 4'b1100 : 4'b0011;
        st_data_s = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        be_s      = 4'b1111;
        st_data_s = wdata_q;
      end
      default: begin
        be_s      = 4'b0000;
        st_data_s = 32'h0000_0000;
      end
    endcase
  end

  // Store commit: only the enabled lanes, never while rst is asserted.
  always_ff @(posedge clk) begin
    if (!rst && commit_s && write_q && !err_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem[word_idx_s][8*i +: 8] <= st_data_s[8*i +: 8];
        end
      end
    end
  end

  // Next-state logic for the IDLE -> WAIT -> RESP handshake sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    funct3_d     = funct3_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d     = req_write;
          addr_d      = req_addr;
          funct3_d    = req_funct3;
          wdata_d     = req_wdata;
          cnt_d       = 4'(WAIT_CYCLES);
          req_ready_d = 1'b0;
          state_d     = ST_WAIT;
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          resp_valid_d = 1'b1;
          resp_err_d   = err_s;
          resp_rdata_d = (err_s || write_q) ? 32'h0000_0000 : load_val_s;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_rdata_d = 32'h0000_0000;
          resp_err_d   = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          resp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        cnt_d        = 4'd0;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0000_0000;
        resp_err_d   = 1'b0;
      end
    endcase
  end

  // State, latched request and registered outputs; async reset aborts any access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      addr_q       <= 32'h0000_0000;
      funct3_q     <= 3'b000;
      wdata_q      <= 32'h0000_0000;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      funct3_q     <= funct3_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
